wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin Wishbone arbiter that places `num_masters` bus masters (e.g. instruction fetch and load/store unit) onto a single Wishbone master port. The block sits directly upstream of the address-decoding slave multiplexer and drives its master-side inputs. It holds each grant for a full `cyc` tenure, which keeps bursts intact. A built-in response watchdog terminates stalled transfers with an error, so the multiplexer can safely stall on unmapped addresses.

## Interface
- `dw`, 32, data width
- `aw`, 32, address width
- `num_masters`, 2, number of requesting masters (≥1)
- `TIMEOUT`, 255, cycles a strobed transfer may wait for ack/err/rty before the watchdog fires; 0 disables the watchdog

- `wb_clk_i` in 1 — single clock, all logic on rising edge
- `wb_rst_i` in 1 — reset, synchronous, active-low
- `wbm_adr_i` in num_masters*aw — master addresses, master i at [i*aw+:aw]
- `wbm_dat_i` in num_masters*dw — master write data
- `wbm_sel_i` in num_masters*4 — byte selects
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i` in num_masters — per-master controls
- `wbm_cti_i` in num_masters*3, `wbm_bte_i` in num_masters*2 — burst tags
- `wbm_dat_o` out num_masters*dw — read data, broadcast to all masters
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o` out num_masters — responses, granted master only
- `wbs_adr_o` out aw, `wbs_dat_o` out dw, `wbs_sel_o` out 4, `wbs_we_o` out 1, `wbs_cyc_o` out 1, `wbs_stb_o` out 1, `wbs_cti_o` out 3, `wbs_bte_o` out 2 — to downstream multiplexer
- `wbs_dat_i` in dw, `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i` in 1 — from downstream multiplexer

## Operation
- **State:** IDLE/BUSY flag, `grant` index, `last_grant` index, watchdog counter of width `$clog2(TIMEOUT+1)`.
- **IDLE:**
  - `wbs_cyc_o` = `wbs_stb_o` = 0.
  - If any `wbm_cyc_i[i]` = 1, the edge loads `grant` with the first requesting index searching `last_grant+1, last_grant+2, …` modulo `num_masters`, and the state becomes BUSY.
- **BUSY:**
  - Granted master's adr/dat/sel/we/cti/bte pass combinationally to the `wbs_*` outputs.
  - `wbs_cyc_o` = `wbm_cyc_i[grant]`.
  - `wbs_stb_o` = `wbm_stb_i[grant]` & ~`wd_fire`.
  - Responses route to index `grant` only; all other masters see 0.
  - `wbm_dat_o` = `{num_masters{wbs_dat_i}}`.
  - When `wbm_cyc_i[grant]` = 0, the edge sets state to IDLE and `last_grant <= grant`.
  - Grant is never revoked while the granted master holds `cyc`. Bursts and `stb` gaps inside a tenure keep the grant.
- **Watchdog** (BUSY only, `TIMEOUT` > 0):
  - Counter increments each cycle with cyc&stb high and no ack/err/rty.
  - Counter clears on any response, on stb low, or in IDLE.
  - `wd_fire` = (counter == `TIMEOUT`).
  - On the fire cycle: `wbm_err_o[grant]` = 1, `wbs_stb_o` forced 0, counter clears.
  - A slave response arriving in the fire cycle is ignored; err wins.
- **Simultaneous events:**
  - Granted master drops cyc while others request: one IDLE cycle follows, then re-arbitration excludes nothing; the round-robin pointer provides fairness.
- **Reset:**
  - Reset asserted mid-transfer: on the next edge, state = IDLE, `grant` = 0, `last_grant` = `num_masters`-1 (master 0 wins first), counter = 0.
  - Outputs follow combinationally from that state: `wbs_cyc_o`/`wbs_stb_o` = 0, all `wbm_ack_o`/`err_o`/`rty_o` = 0.
  - Remaining `wbs_*` outputs show master 0's signals; `wbm_dat_o` mirrors `wbs_dat_i`.

## Timing
- Arbitration latency: 1 cycle from first `wbm_cyc_i` high (in IDLE) to `wbs_cyc_o` high.
- Data/response path: 0 cycles, purely combinational through the arbiter.
- Tenure gap: at least 1 IDLE cycle between consecutive grants, including back-to-back by the same master.
- Watchdog fires in the cycle when the counter reaches `TIMEOUT`, i.e. the (`TIMEOUT`+1)th consecutive unanswered strobed cycle.
- No combinational path from `wbm_cyc_i` to `grant`. `grant` changes only at an IDLE edge.

## Test plan
- **Single read:** After reset, master 1 raises cyc/stb with adr=0x0000_1000 → `wbs_cyc_o` high one cycle later, `wbs_adr_o`=0x0000_1000. Slave returns ack with dat=0xDEADBEEF → `wbm_ack_o`=2'b10, master 1 reads 0xDEADBEEF.
- **Simultaneous request after reset:** Masters 0 and 1 request together → master 0 granted first. After master 0 drops cyc, one IDLE cycle, then master 1 granted.
- **Round-robin fairness:** Both masters continuously re-request with one-transfer tenures over 10 tenures → grants alternate 0,1,0,1…, never the same master twice in a row.
- **Burst hold:** Master 0 issues a 4-beat incrementing burst (cti=010, final beat 111) while master 1 requests → `wbs_cyc_o` stays high across all 4 acks with grant 0. Master 1 is granted only after master 0 drops cyc.
- **Watchdog:** `TIMEOUT`=8, slave never responds → `wbm_err_o[grant]` pulses exactly on the 9th strobed cycle, with `wbs_stb_o`=0 in that cycle. Counter restarts if the master keeps strobing.
- **Reset mid-transfer:** Assert `wb_rst_i`=0 during master 1's wait state → next edge `wbs_cyc_o`=0, no ack forwarded. After release, master 0 has priority.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter that places num_masters Wishbone masters
// onto one Wishbone master port. A grant lasts for the whole cyc tenure of
// the granted master, so bursts stay intact. A response watchdog ends a
// strobed transfer with an error if it is not answered in time.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-low reset
//   wbm_*_i                       packed per-master request signals
//   wbm_dat_o                     read data, broadcast to every master
//   wbm_ack_o/err_o/rty_o         responses, driven to the granted master only
//   wbs_*_o                       granted master's request, to the slave mux
//   wbs_dat_i/ack_i/err_i/rty_i   response from the slave mux
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no tenure; wbs_cyc_o low; next edge picks a requester
// ST_BUSY | grant_q owns the port until it drops cyc; watchdog runs

module wb_arbiter #(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int num_masters = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,

    input  logic [num_masters*aw-1:0] wbm_adr_i,
    input  logic [num_masters*dw-1:0] wbm_dat_i,
    input  logic [num_masters*4-1:0]  wbm_sel_i,
    input  logic [num_masters-1:0]    wbm_we_i,
    input  logic [num_masters-1:0]    wbm_cyc_i,
    input  logic [num_masters-1:0]    wbm_stb_i,
    input  logic [num_masters*3-1:0]  wbm_cti_i,
    input  logic [num_masters*2-1:0]  wbm_bte_i,
    output logic [num_masters*dw-1:0] wbm_dat_o,
    output logic [num_masters-1:0]    wbm_ack_o,
    output logic [num_masters-1:0]    wbm_err_o,
    output logic [num_masters-1:0]    wbm_rty_o,

    output logic [aw-1:0]             wbs_adr_o,
    output logic [dw-1:0]             wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [dw-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i
);

    localparam int GW = (num_masters > 1) ? $clog2(num_masters) : 1;
    // A disabled watchdog still gets a 1-bit counter so the vector is legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(num_masters - 1);
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   wd_cnt_q, wd_cnt_d;

    logic [GW-1:0]   rr_pick;
    logic            rr_found;
    logic            g_cyc;
    logic            g_stb;
    logic            any_resp;
    logic            wd_fire;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    // Search starts one past the previous winner, so the last owner has the
    // lowest priority in the next arbitration.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = grant_q;
        for (int k = 1; k <= num_masters; k++) begin
            if (!rr_found && wbm_cyc_i[(int'(last_grant_q) + k) % num_masters]) begin
                rr_found = 1'b1;
                rr_pick  = GW'((int'(last_grant_q) + k) % num_masters);
            end
        end
    end

    // Request path is a plain mux on grant_q; in IDLE it shows the last
    // grant (master 0 after reset) with cyc/stb held low.
    assign wbs_adr_o = wbm_adr_i[grant_q*aw +: aw];
    assign wbs_dat_o = wbm_dat_i[grant_q*dw +: dw];
    assign wbs_sel_o = wbm_sel_i[grant_q*4 +: 4];
    assign wbs_we_o  = wbm_we_i[grant_q];
    assign wbs_cti_o = wbm_cti_i[grant_q*3 +: 3];
    assign wbs_bte_o = wbm_bte_i[grant_q*2 +: 2];
    assign wbm_dat_o = {num_masters{wbs_dat_i}};

    assign g_cyc    = wbm_cyc_i[grant_q];
    assign g_stb    = wbm_stb_i[grant_q];
    assign any_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign wd_fire  = (TIMEOUT > 0) && (state_q == ST_BUSY) && (wd_cnt_q == WD_LIMIT);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wd_cnt_d     = '0;
        wbs_cyc_o    = 1'b0;
        wbs_stb_o    = 1'b0;
        wbm_ack_o    = '0;
        wbm_err_o    = '0;
        wbm_rty_o    = '0;

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                wbs_cyc_o = g_cyc;
                wbs_stb_o = g_stb & ~wd_fire;

                // On the fire cycle the synthesised error replaces whatever
                // the slave says, so a late ack cannot complete the transfer.
                wbm_ack_o[grant_q] = wbs_ack_i & ~wd_fire;
                wbm_rty_o[grant_q] = wbs_rty_i & ~wd_fire;
                wbm_err_o[grant_q] = wbs_err_i | wd_fire;

                if ((TIMEOUT > 0) && !wd_fire && g_cyc && g_stb && !any_resp) begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end

                if (!g_cyc) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by a randomized phase,
// every cycle compared against a behavioural model of the arbitration rules.

module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;

    logic [N*AW-1:0] wbm_adr_i;
    logic [N*DW-1:0] wbm_dat_i;
    logic [N*4-1:0]  wbm_sel_i;
    logic [N-1:0]    wbm_we_i;
    logic [N-1:0]    wbm_cyc_i;
    logic [N-1:0]    wbm_stb_i;
    logic [N*3-1:0]  wbm_cti_i;
    logic [N*2-1:0]  wbm_bte_i;
    logic [N*DW-1:0] wbm_dat_o;
    logic [N-1:0]    wbm_ack_o;
    logic [N-1:0]    wbm_err_o;
    logic [N-1:0]    wbm_rty_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [3:0]      wbs_sel_o;
    logic            wbs_we_o;
    logic            wbs_cyc_o;
    logic            wbs_stb_o;
    logic [2:0]      wbs_cti_o;
    logic [1:0]      wbs_bte_o;
    logic [DW-1:0]   wbs_dat_i;
    logic            wbs_ack_i;
    logic            wbs_err_i;
    logic            wbs_rty_i;

    wb_arbiter #(
        .dw(DW), .aw(AW), .num_masters(N), .TIMEOUT(TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wbm_adr_i(wbm_adr_i),
        .wbm_dat_i(wbm_dat_i),
        .wbm_sel_i(wbm_sel_i),
        .wbm_we_i (wbm_we_i),
        .wbm_cyc_i(wbm_cyc_i),
        .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i),
        .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o),
        .wbs_dat_o(wbs_dat_o),
        .wbs_sel_o(wbs_sel_o),
        .wbs_we_o (wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o),
        .wbs_stb_o(wbs_stb_o),
        .wbs_cti_o(wbs_cti_o),
        .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i),
        .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: whether a tenure is open, who owns it, who owned the
    // previous one, and how many strobed cycles in a row went unanswered.
    bit m_busy;
    int m_g;
    int m_last;
    int m_wait;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_last = N - 1;
        m_wait = 0;
    endtask

    // Mid-cycle: compare every output against the model for current inputs.
    task automatic cycle_begin();
        logic [N-1:0] oh;
        bit fire;
        #4;
        oh = '0;
        oh[m_g] = 1'b1;
        fire = m_busy && (m_wait == TO);
        check("cyc_o", wbs_cyc_o, m_busy ? wbm_cyc_i[m_g] : 1'b0);
        check("stb_o", wbs_stb_o, m_busy && wbm_stb_i[m_g] && !fire);
        check("ack_o", wbm_ack_o, (m_busy && wbs_ack_i && !fire) ? oh : '0);
        check("err_o", wbm_err_o, (m_busy && (wbs_err_i || fire)) ? oh : '0);
        check("rty_o", wbm_rty_o, (m_busy && wbs_rty_i && !fire) ? oh : '0);
        check("adr_o", wbs_adr_o, wbm_adr_i[m_g*AW +: AW]);
        check("wdat_o", wbs_dat_o, wbm_dat_i[m_g*DW +: DW]);
        check("ctl_o", {wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o},
              {wbm_sel_i[m_g*4 +: 4], wbm_we_i[m_g], wbm_cti_i[m_g*3 +: 3], wbm_bte_i[m_g*2 +: 2]});
        check("rdat_o", wbm_dat_o, {N{wbs_dat_i}});
    endtask

    // Apply the clock edge to the model, then advance to just after the edge.
    task automatic cycle_end();
        int best;
        int bd;
        int d;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            m_wait = 0;
            best = -1;
            bd = N;
            for (int i = 0; i < N; i++) begin
                d = (i - m_last - 1 + N) % N;   // distance after the last winner
                if (wbm_cyc_i[i] && d < bd) begin
                    bd = d;
                    best = i;
                end
            end
            if (best >= 0) begin
                m_busy = 1'b1;
                m_g = best;
            end
        end else begin
            if (m_wait == TO)
                m_wait = 0;
            else if (wbm_cyc_i[m_g] && wbm_stb_i[m_g] && !(wbs_ack_i || wbs_err_i || wbs_rty_i))
                m_wait = m_wait + 1;
            else
                m_wait = 0;
            if (!wbm_cyc_i[m_g]) begin
                m_busy = 1'b0;
                m_last = m_g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        cycle_begin();
        cycle_end();
    endtask

    task automatic drive_m(input int i, input logic c, input logic s,
                           input logic [AW-1:0] a, input logic [2:0] ct);
        wbm_cyc_i[i] = c;
        wbm_stb_i[i] = s;
        wbm_adr_i[i*AW +: AW] = a;
        wbm_cti_i[i*3 +: 3] = ct;
    endtask

    task automatic slave(input logic a, input logic e, input logic r, input logic [DW-1:0] d);
        wbs_ack_i = a;
        wbs_err_i = e;
        wbs_rty_i = r;
        wbs_dat_i = d;
    endtask

    initial begin
        int drop;
        int prev;
        int winner;
        int tenures;
        bit fire_k;

        rst_n     = 1'b0;
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_sel_i = '0;
        wbm_we_i  = '0;
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
        wbm_cti_i = '0;
        wbm_bte_i = '0;
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        cycle_begin();
        check("rst_cyc", wbs_cyc_o, 1'b0);
        check("rst_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, '0);
        cycle_end();
        rst_n = 1'b1;

        // Single read by master 1.
        wbm_dat_i = {32'h1111_2222, 32'h3333_4444};
        wbm_sel_i = 8'hF3;
        wbm_we_i  = 2'b01;
        drive_m(1, 1'b1, 1'b1, 32'h0000_1000, 3'b000);
        cycle_begin();
        check("rd_arb_latency", wbs_cyc_o, 1'b0);
        cycle_end();
        slave(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        cycle_begin();
        check("rd_cyc", wbs_cyc_o, 1'b1);
        check("rd_adr", wbs_adr_o, 32'h0000_1000);
        check("rd_ack", wbm_ack_o, 2'b10);
        check("rd_data", wbm_dat_o[63:32], 32'hDEAD_BEEF);
        cycle_end();
        drive_m(1, 1'b0, 1'b0, 32'h0000_1000, 3'b000);
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();

        // Simultaneous request after reset: master 0 first.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        drive_m(0, 1'b1, 1'b1, 32'h0000_00A0, 3'b000);
        drive_m(1, 1'b1, 1'b1, 32'h0000_00B0, 3'b000);
        cycle();
        slave(1'b1, 1'b0, 1'b0, 32'h5);
        cycle_begin();
        check("sim_first", wbs_adr_o, 32'h0000_00A0);
        check("sim_ack0", wbm_ack_o, 2'b01);
        cycle_end();
        drive_m(0, 1'b0, 1'b0, 32'h0000_00A0, 3'b000);
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        cycle_begin();
        check("sim_gap", wbs_cyc_o, 1'b0);
        cycle_end();
        cycle_begin();
        check("sim_second_cyc", wbs_cyc_o, 1'b1);
        check("sim_second_adr", wbs_adr_o, 32'h0000_00B0);
        cycle_end();
        drive_m(1, 1'b0, 1'b0, 32'h0000_00B0, 3'b000);
        cycle();

        // Fairness: both keep requesting, one-transfer tenures.
        drop = -1;
        prev = -1;
        tenures = 0;
        drive_m(0, 1'b1, 1'b1, 32'h0000_0100, 3'b000);
        drive_m(1, 1'b1, 1'b1, 32'h0000_0200, 3'b000);
        slave(1'b1, 1'b0, 1'b0, 32'h77);
        for (int c = 0; c < 80 && tenures < 10; c++) begin
            wbm_cyc_i = 2'b11;
            wbm_stb_i = 2'b11;
            if (drop >= 0) begin
                wbm_cyc_i[drop] = 1'b0;
                wbm_stb_i[drop] = 1'b0;
            end
            cycle_begin();
            drop = -1;
            if (wbs_cyc_o === 1'b1) begin
                winner = (wbs_adr_o == 32'h0000_0200) ? 1 : 0;
                if (prev >= 0) check("rr_alternate", winner, 1 - prev);
                prev = winner;
                tenures++;
                drop = winner;
            end
            cycle_end();
        end
        check("rr_tenures", tenures, 10);
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        cycle();

        // Burst hold: master 0 keeps the port for 4 beats while master 1 waits.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        drive_m(0, 1'b1, 1'b1, 32'h0000_0100, 3'b010);
        drive_m(1, 1'b1, 1'b1, 32'h0000_0200, 3'b000);
        cycle();
        for (int b = 0; b < 4; b++) begin
            drive_m(0, 1'b1, 1'b1, 32'h0000_0100 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
            slave(1'b1, 1'b0, 1'b0, $urandom);
            cycle_begin();
            check("burst_cyc", wbs_cyc_o, 1'b1);
            check("burst_adr", wbs_adr_o, 32'h0000_0100 + 32'(4 * b));
            check("burst_cti", wbs_cti_o, (b == 3) ? 3'b111 : 3'b010);
            check("burst_ack", wbm_ack_o, 2'b01);
            cycle_end();
        end
        drive_m(0, 1'b0, 1'b0, 32'h0000_0100, 3'b000);
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        cycle_begin();
        check("burst_gap", wbs_cyc_o, 1'b0);
        cycle_end();
        cycle_begin();
        check("burst_next", wbs_adr_o, 32'h0000_0200);
        cycle_end();
        drive_m(1, 1'b0, 1'b0, 32'h0000_0200, 3'b000);
        cycle();

        // Watchdog: no slave response; fires on strobed cycles 9 and 18.
        drive_m(0, 1'b1, 1'b1, 32'h0000_0F00, 3'b000);
        cycle();
        for (int k = 1; k <= 20; k++) begin
            slave((k == 18) ? 1'b1 : 1'b0, 1'b0, 1'b0, 32'h0);
            fire_k = (k == 9) || (k == 18);
            cycle_begin();
            check("wd_err", wbm_err_o, fire_k ? 2'b01 : 2'b00);
            check("wd_stb", wbs_stb_o, !fire_k);
            if (k == 18) check("wd_ack_masked", wbm_ack_o, 2'b00);
            cycle_end();
        end
        drive_m(0, 1'b0, 1'b0, 32'h0000_0F00, 3'b000);
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        cycle();

        // Reset during master 1's wait state.
        drive_m(0, 1'b0, 1'b0, 32'h0000_3000, 3'b000);
        drive_m(1, 1'b1, 1'b1, 32'h0000_2000, 3'b000);
        cycle();
        cycle_begin();
        check("rstmid_busy", wbs_cyc_o, 1'b1);
        cycle_end();
        rst_n = 1'b0;
        cycle();
        slave(1'b1, 1'b0, 1'b0, 32'hCAFE_0001);
        cycle_begin();
        check("rstmid_cyc", wbs_cyc_o, 1'b0);
        check("rstmid_ack", wbm_ack_o, 2'b00);
        check("rstmid_adr", wbs_adr_o, 32'h0000_3000);
        cycle_end();
        rst_n = 1'b1;
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        drive_m(0, 1'b1, 1'b1, 32'h0000_3000, 3'b000);
        cycle();
        cycle_begin();
        check("rstmid_prio", wbs_adr_o, 32'h0000_3000);
        check("rstmid_prio_cyc", wbs_cyc_o, 1'b1);
        cycle_end();
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
        cycle();

        // Randomized traffic; every other 100-cycle window the slave is slow.
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) wbm_cyc_i[i] = ~wbm_cyc_i[i];
                wbm_stb_i[i] = wbm_cyc_i[i] & ($urandom_range(0, 7) != 0);
                wbm_adr_i[i*AW +: AW] = $urandom;
                wbm_dat_i[i*DW +: DW] = $urandom;
                wbm_sel_i[i*4 +: 4] = 4'($urandom_range(0, 15));
                wbm_we_i[i] = 1'($urandom_range(0, 1));
                wbm_cti_i[i*3 +: 3] = 3'($urandom_range(0, 7));
                wbm_bte_i[i*2 +: 2] = 2'($urandom_range(0, 3));
            end
            if (((c / 100) % 2) == 1)
                slave($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 39) == 0, $urandom);
            else
                slave($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 15) == 0, $urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
